bram_port_arbiter: RTL and testbench

Arbitrates one port of a single-port `bram_module` instance between two requesters. Typical pairing: the CPU data-memory interface on master 0 and a loader/debug DMA on master 1. It drives the BRAM's port A (`ena`, `wea`, `addra`, `dina`) and returns `douta` to whichever master issued the read. It supports bus locking with a bounded hold time, and selectable fixed-priority or round-robin policy.

---
 rtl/bram_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares port A of a single-port BRAM between two masters (typically the CPU
// data interface on master 0 and a loader/debug DMA on master 1).
// Arbitration is zero-cycle: the grant and the RAM command are issued in the
// same cycle as the request. Read data returns one cycle later to the master
// that issued the read.
//
// A master can hold the port with a lock for at most LOCK_MAX consecutive
// cycles. When a lock runs out, the arbitration in that same cycle favours the
// other master.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   - an IDLE tie goes to the master that was not granted last
//   undefined - an IDLE tie always goes to master 0 (fixed priority)
//
// Parameters:
//   RAM_ADDR_WIDTH  word-address width driven to the BRAM
//   DATA_WIDTH      data width; byte enables are DATA_WIDTH/8 bits
//   LOCK_MAX        maximum consecutive locked cycles (>= 1)
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   mN_req_i / mN_lock_i     request and keep-ownership flags per master
//   mN_we_i                  byte write enables (all zero = read)
//   mN_addr_i / mN_wdata_i   byte address and write data
//   mN_gnt_o                 access accepted this cycle (combinational)
//   mN_rvalid_o / mN_rdata_o read response, one cycle after a read grant
//   ram_en_o / ram_we_o      BRAM enable and byte write enables
//   ram_addr_o / ram_din_o   BRAM word address and write data
//   ram_dout_i               BRAM read data (one cycle after the address)
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int LOCK_MAX       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_req_i,
  input  logic                      m0_lock_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_we_i,
  input  logic [31:0]               m0_addr_i,
  input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
  output logic                      m0_gnt_o,
  output logic                      m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m0_rdata_o,
  input  logic                      m1_req_i,
  input  logic                      m1_lock_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_we_i,
  input  logic [31:0]               m1_addr_i,
  input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
  output logic                      m1_gnt_o,
  output logic                      m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m1_rdata_o,
  output logic                      ram_en_o,
  output logic [DATA_WIDTH/8-1:0]   ram_we_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_din_o,
  input  logic [DATA_WIDTH-1:0]     ram_dout_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  state_t           w_arb_next;
  logic             r_last_gnt;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_arb_cnt;
  logic [1:0]       r_rd_pend;
  logic             w_expired;
  logic             w_idle_pref1;
  logic             w_arb_pref1;
  logic             w_arb_g0;
  logic             w_arb_g1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_g0;
  logic             w_g1;
  logic             w_unused_addr;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_idle_pref1 = ~r_last_gnt;
`else
  assign w_idle_pref1 = 1'b0;
`endif

  assign w_expired = (r_lock_cnt == LOCK_MAX_C);

  // An expired lock arbitrates like IDLE, but the tie goes to the other master.
  assign w_arb_pref1 = (r_state == ST_LOCK0) ? 1'b1 :
                       (r_state == ST_LOCK1) ? 1'b0 : w_idle_pref1;

  assign w_arb_g0 = m0_req_i & (~m1_req_i | ~w_arb_pref1);
  assign w_arb_g1 = m1_req_i & (~m0_req_i |  w_arb_pref1);

  // Only the granted master's lock flag can open a lock.
  assign w_arb_next = (w_arb_g0 && m0_lock_i) ? ST_LOCK0 :
                      (w_arb_g1 && m1_lock_i) ? ST_LOCK1 : ST_IDLE;
  assign w_arb_cnt  = (w_arb_next == ST_IDLE) ? CNT_ZERO : CNT_ONE;

  // Next-state, lock counter and grant decode
  always_comb begin
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        w_gnt0       = w_arb_g0;
        w_gnt1       = w_arb_g1;
        w_next_state = w_arb_next;
        w_next_cnt   = w_arb_cnt;
      end
      ST_LOCK0: begin
        if (w_expired) begin
          w_gnt0       = w_arb_g0;
          w_gnt1       = w_arb_g1;
          w_next_state = w_arb_next;
          w_next_cnt   = w_arb_cnt;
        end else if (m0_lock_i) begin
          w_gnt0     = m0_req_i;
          w_next_cnt = r_lock_cnt + CNT_ONE;
        end else begin
          // Dropping the lock still allows this final access.
          w_gnt0       = m0_req_i;
          w_next_state = ST_IDLE;
          w_next_cnt   = CNT_ZERO;
        end
      end
      ST_LOCK1: begin
        if (w_expired) begin
          w_gnt0       = w_arb_g0;
          w_gnt1       = w_arb_g1;
          w_next_state = w_arb_next;
          w_next_cnt   = w_arb_cnt;
        end else if (m1_lock_i) begin
          w_gnt1     = m1_req_i;
          w_next_cnt = r_lock_cnt + CNT_ONE;
        end else begin
          w_gnt1       = m1_req_i;
          w_next_state = ST_IDLE;
          w_next_cnt   = CNT_ZERO;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = CNT_ZERO;
      end
    endcase
  end

  // Grants are suppressed while reset is held.
  assign w_g0 = w_gnt0 & ~reset;
  assign w_g1 = w_gnt1 & ~reset;

  // State, lock counter, grant history and read-pending flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_lock_cnt <= CNT_ZERO;
      r_rd_pend  <= 2'b00;
    end else begin
      r_state    <= w_next_state;
      r_lock_cnt <= w_next_cnt;
      if (w_g0) begin
        r_last_gnt <= 1'b0;
      end else if (w_g1) begin
        r_last_gnt <= 1'b1;
      end else begin
        r_last_gnt <= r_last_gnt;
      end
      r_rd_pend <= {w_g1 & ~(|m1_we_i), w_g0 & ~(|m0_we_i)};
    end
  end

  assign m0_gnt_o = w_g0;
  assign m1_gnt_o = w_g1;

  assign ram_en_o   = w_g0 | w_g1;
  assign ram_we_o   = w_g0 ? m0_we_i : (w_g1 ? m1_we_i : {BE_W{1'b0}});
  assign ram_addr_o = w_g0 ? m0_addr_i[RAM_ADDR_WIDTH+1:2] :
                      (w_g1 ? m1_addr_i[RAM_ADDR_WIDTH+1:2] : {RAM_ADDR_WIDTH{1'b0}});
  assign ram_din_o  = w_g0 ? m0_wdata_i : (w_g1 ? m1_wdata_i : {DATA_WIDTH{1'b0}});

  // A read pending across a reset edge must not produce a response.
  assign m0_rvalid_o = r_rd_pend[0] & ~reset;
  assign m1_rvalid_o = r_rd_pend[1] & ~reset;
  assign m0_rdata_o  = m0_rvalid_o ? ram_dout_i : {DATA_WIDTH{1'b0}};
  assign m1_rdata_o  = m1_rvalid_o ? ram_dout_i : {DATA_WIDTH{1'b0}};

  // Byte-offset and out-of-range address bits are intentionally ignored.
  assign w_unused_addr = ^{m0_addr_i[31:RAM_ADDR_WIDTH+2], m0_addr_i[1:0],
                           m1_addr_i[31:RAM_ADDR_WIDTH+2], m1_addr_i[1:0]};

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Drives bram_port_arbiter (LOCK_MAX = 4) against a behavioural BRAM with a
// one-cycle read latency. Each stimulus record carries the inputs for one
// cycle together with the expected grants and, for a granted read, the
// expected read data. Expected read responses are queued at the grant and
// compared on the following cycle.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam logic [3:0] RD = 4'h0;
  localparam logic [3:0] WF = 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        r0;
    logic        l0;
    logic [3:0]  we0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        l1;
    logic [3:0]  we1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          due;
    logic        m;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req_i, m0_lock_i, m1_req_i, m1_lock_i;
  logic [3:0]  m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_din_o;
  logic [31:0] ram_dout_i;

  logic [31:0] mem [0:1023];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  sb_t  sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .RAM_ADDR_WIDTH(10),
    .DATA_WIDTH    (32),
    .LOCK_MAX      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req_i   (m0_req_i),
    .m0_lock_i  (m0_lock_i),
    .m0_we_i    (m0_we_i),
    .m0_addr_i  (m0_addr_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_gnt_o   (m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o (m0_rdata_o),
    .m1_req_i   (m1_req_i),
    .m1_lock_i  (m1_lock_i),
    .m1_we_i    (m1_we_i),
    .m1_addr_i  (m1_addr_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_gnt_o   (m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o (m1_rdata_o),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_din_o  (ram_din_o),
    .ram_dout_i (ram_dout_i)
  );

  // Behavioural BRAM: byte-write, read-first, one-cycle read latency
  always @(posedge clk) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_din_o[8*b +: 8];
      end
      ram_dout_i <= mem[ram_addr_o];
    end
  end

  function automatic vec_t mkv(input logic rst,
                               input logic r0, input logic l0, input logic [3:0] we0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic l1, input logic [3:0] we1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic g0, input logic g1, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.l0 = l0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.l1 = l1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Apply one record, compare at the falling edge, then advance one cycle.
  task automatic run_vec(input vec_t v);
    logic [31:0] e_addr, e_din, e_rd0, e_rd1;
    logic [3:0]  e_we;
    logic        e_rv0, e_rv1;
    sb_t         e;
    reset = v.rst;
    m0_req_i = v.r0; m0_lock_i = v.l0; m0_we_i = v.we0; m0_addr_i = v.a0; m0_wdata_i = v.d0;
    m1_req_i = v.r1; m1_lock_i = v.l1; m1_we_i = v.we1; m1_addr_i = v.a1; m1_wdata_i = v.d1;
    @(negedge clk);
    e_we   = v.g0 ? v.we0 : (v.g1 ? v.we1 : 4'h0);
    e_addr = v.g0 ? 32'(v.a0[11:2]) : (v.g1 ? 32'(v.a1[11:2]) : 32'h0);
    e_din  = v.g0 ? v.d0 : (v.g1 ? v.d1 : 32'h0);
    chk("m0_gnt",   32'(m0_gnt_o),   32'(v.g0));
    chk("m1_gnt",   32'(m1_gnt_o),   32'(v.g1));
    chk("ram_en",   32'(ram_en_o),   32'(v.g0 | v.g1));
    chk("ram_we",   32'(ram_we_o),   32'(e_we));
    chk("ram_addr", 32'(ram_addr_o), e_addr);
    chk("ram_din",  ram_din_o,       e_din);
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (!v.rst) begin
        if (e.m) begin e_rv1 = 1'b1; e_rd1 = e.data; end
        else     begin e_rv0 = 1'b1; e_rd0 = e.data; end
      end
    end
    chk("m0_rvalid", 32'(m0_rvalid_o), 32'(e_rv0));
    chk("m1_rvalid", 32'(m1_rvalid_o), 32'(e_rv1));
    chk("m0_rdata",  m0_rdata_o,       e_rd0);
    chk("m1_rdata",  m1_rdata_o,       e_rd1);
    if (!v.rst && v.g0 && v.we0 == 4'h0) begin
      e.due = cyc + 1; e.m = 1'b0; e.data = v.rd; sb_q.push_back(e);
    end
    if (!v.rst && v.g1 && v.we1 == 4'h0) begin
      e.due = cyc + 1; e.m = 1'b1; e.data = v.rd; sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    m0_req_i = 1'b0; m0_lock_i = 1'b0; m0_we_i = 4'h0; m0_addr_i = 32'h0; m0_wdata_i = 32'h0;
    m1_req_i = 1'b0; m1_lock_i = 1'b0; m1_we_i = 4'h0; m1_addr_i = 32'h0; m1_wdata_i = 32'h0;
    @(posedge clk);
    #1;

    // Reset held 3 cycles with both masters requesting: everything quiet.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mkv(1'b1, 1'b1,1'b0,RD,32'h10,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b0,1'b0,32'h0));
    // First cycle after reset: tie goes to m0 in both builds.
    tbl.push_back(mkv(1'b0, 1'b1,1'b0,WF,32'h10,32'hDEADBEEF, 1'b1,1'b0,WF,32'h8,32'hAABBCCDD, 1'b1,1'b0,32'h0));
    // m1 held its request and is now alone.
    tbl.push_back(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b0,WF,32'h8,32'hAABBCCDD, 1'b0,1'b1,32'h0));
    // Single read of byte address 0x10 -> word 4.
    tbl.push_back(mkv(1'b0, 1'b1,1'b0,RD,32'h10,32'h0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b0,32'hDEADBEEF));
    // Partial byte write by m1, then read back of word 2.
    tbl.push_back(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b0,4'b0011,32'h8,32'h12345678, 1'b0,1'b1,32'h0));
    tbl.push_back(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b0,1'b1,32'hAABB5678));
    // Contention: both masters read for 6 cycles.
    for (int k = 0; k < 6; k++) begin
      if (RR_BUILD && (k % 2 == 1))
        tbl.push_back(mkv(1'b0, 1'b1,1'b0,RD,32'h10,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b0,1'b1,32'hAABB5678));
      else
        tbl.push_back(mkv(1'b0, 1'b1,1'b0,RD,32'h10,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b1,1'b0,32'hDEADBEEF));
    end
    tbl.push_back(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b0,1'b0,32'h0));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Lock timeout: m1 locks alone, m0 then requests throughout.
    run_vec(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b1,RD,32'h8,32'h0, 1'b0,1'b1,32'hAABB5678));
    for (int k = 0; k < 3; k++)
      run_vec(mkv(1'b0, 1'b1,1'b0,RD,32'h10,32'h0, 1'b1,1'b1,RD,32'h8,32'h0, 1'b0,1'b1,32'hAABB5678));
    run_vec(mkv(1'b0, 1'b1,1'b0,RD,32'h10,32'h0, 1'b1,1'b1,RD,32'h8,32'h0, 1'b1,1'b0,32'hDEADBEEF));
    run_vec(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b0,1'b0,32'h0));

    // Lock held by m0, released by dropping lock; m1 blocked until then.
    run_vec(mkv(1'b0, 1'b1,1'b1,RD,32'h10,32'h0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b0,32'hDEADBEEF));
    run_vec(mkv(1'b0, 1'b1,1'b1,RD,32'h10,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b1,1'b0,32'hDEADBEEF));
    run_vec(mkv(1'b0, 1'b0,1'b1,RD,32'h10,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b0,1'b0,32'h0));
    run_vec(mkv(1'b0, 1'b1,1'b0,RD,32'h10,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b1,1'b0,32'hDEADBEEF));
    run_vec(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b0,1'b1,32'hAABB5678));

    // Reset mid-read: locked read by m0, reset next cycle, m1 then free.
    run_vec(mkv(1'b0, 1'b1,1'b1,RD,32'h10,32'h0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b0,32'hDEADBEEF));
    run_vec(mkv(1'b1, 1'b0,1'b0,RD,32'h0,32'h0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b0,1'b0,32'h0));
    run_vec(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b0,1'b1,32'hAABB5678));
    run_vec(mkv(1'b0, 1'b1,1'b0,RD,32'h10,32'h0, 1'b1,1'b0,RD,32'h8,32'h0, 1'b1,1'b0,32'hDEADBEEF));
    run_vec(mkv(1'b0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b0,1'b0,RD,32'h0,32'h0, 1'b0,1'b0,32'h0));

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
